input_debouncer: RTL

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 33 +++
 rtl/debounce_channel.sv | 66 ++++++
 rtl/input_debouncer.sv | 36 +++
 3 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the switch/key input debouncer.
package input_debouncer_pkg;

  localparam int NUM_SW              = 10;
  localparam int NUM_KEY             = 4;
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

  // Byte offsets of the switch and key blocks in the input peripheral map
  localparam logic [7:0] IN_SW_START  = 8'h00;
  localparam logic [7:0] IN_KEY_START = 8'h10;

  typedef logic [7:0] press_count_t;

  // A clear that coincides with a press keeps the press, so the count restarts at 1
  function automatic press_count_t next_press_count(
    input press_count_t count,
    input logic         rise,
    input logic         clear
  );
    press_count_t result;
    if (rise && clear) begin
      result = 8'd1;
    end else if (rise) begin
      result = count + 8'd1;
    end else if (clear) begin
      result = 8'd0;
    end else begin
      result = count;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: optional inversion, 2-flop synchronizer, stability
// counter, stable level, edge strobes and a wrapping press counter.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INVERT          = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         raw_in,
  input  logic         count_clear,
  output logic         stable,
  output logic         rise_pulse,
  output logic         fall_pulse,
  output press_count_t press_count
);

  localparam int              CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          rise_r;
  logic          fall_r;
  logic [CW-1:0] count_r;
  press_count_t  press_count_r;
  logic          settle_s;

  // The differing level has now been seen for DEBOUNCE_CYCLES consecutive edges
  assign settle_s = (sync2_r != stable_r) && (count_r == LAST_COUNT);

  // Synchronize, debounce, and register strobes and press count together
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r       <= 1'b0;
      sync2_r       <= 1'b0;
      stable_r      <= 1'b0;
      rise_r        <= 1'b0;
      fall_r        <= 1'b0;
      count_r       <= '0;
      press_count_r <= 8'd0;
    end else begin
      sync1_r <= raw_in ^ INVERT;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        count_r <= '0;
      end else if (settle_s) begin
        count_r  <= '0;
        stable_r <= sync2_r;
      end else begin
        count_r <= count_r + CW'(1);
      end
      rise_r        <= settle_s & sync2_r;
      fall_r        <= settle_s & ~sync2_r;
      press_count_r <= next_press_count(press_count_r, settle_s & sync2_r, count_clear);
    end
  end

  assign stable      = stable_r;
  assign rise_pulse  = rise_r;
  assign fall_pulse  = fall_r;
  assign press_count = press_count_r;

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for the board switches and active-low keys; one independent
// debounce_channel per input pin.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int                    NUM_INPUTS      = NUM_SW + NUM_KEY,
  parameter int                    DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK     = 14'b11110000000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_INPUTS-1:0]      raw_in,
  input  logic [NUM_INPUTS-1:0]      count_clear,
  output logic [NUM_INPUTS-1:0]      stable,
  output logic [NUM_INPUTS-1:0]      rise_pulse,
  output logic [NUM_INPUTS-1:0]      fall_pulse,
  output logic [NUM_INPUTS-1:0][7:0] press_count
);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT_MASK[i])
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .raw_in     (raw_in[i]),
      .count_clear(count_clear[i]),
      .stable     (stable[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .press_count(press_count[i])
    );
  end

endmodule
